// File: rtl/mm_sched_pkg.sv
// Shared definitions for the mm_sched job scheduler: the geometry of the
// matrix-multiply array, the mode encodings and the scheduler state encodings.
package mm_sched_pkg;

  // Matrix and array geometry of the MM controller this scheduler feeds.
  localparam int M  = 16;
  localparam int N  = 32;
  localparam int VL = 8;
  localparam int AD = 8;

  // Command modes, using the same encodings as the MM controller.
  localparam logic [1:0] MODE_INT8     = 2'd0;
  localparam logic [1:0] MODE_INT4     = 2'd1;
  localparam logic [1:0] MODE_INT4_VSQ = 2'd2;

  // tile_done pulses a well-formed job produces, and the post-matrix PPU flush window.
  localparam int EXP_TILES_DEF = (N / AD) * (M / VL);
  localparam int DRAIN_CYC_DEF = VL;

  // Scheduler states. The encoding is kept as plain constants so that older
  // tools and debug scripts keyed on the raw values keep working.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

endpackage

// File: rtl/mm_sched_sync_fifo.sv
// Synchronous command FIFO for mm_sched. The head entry is visible on rdata
// without a read request. flush empties the FIFO in one cycle and takes
// priority over a push or pop in the same cycle. DEPTH must be a power of 2.
module mm_sched_sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty && !flush;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && !flush && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the payload array has no reset; only pointers and count decide validity,
  // so clearing the data would cost a reset net per bit for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mm_sched.sv
// mm_sched: job scheduler in front of the matrix-multiply controller.
// Queues (mode, id) commands, issues one start pulse per job, counts tiles,
// waits out the post-matrix drain window and returns a completion record.
// Optional build macro MM_SCHED_PERF_EN adds o_perf_cycles / o_perf_stall.
module mm_sched
  import mm_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 4,
  parameter int TILE_W     = 16,
  parameter int DRAIN_CYC  = DRAIN_CYC_DEF,
  parameter int EXP_TILES  = EXP_TILES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_mode,
  input  logic [ID_W-1:0]   i_cmd_id,
  input  logic              i_flush,
  output logic              o_mm_start,
  output logic [1:0]        o_mm_mode,
  input  logic              i_mm_tile_done,
  input  logic              i_mm_mtrx_done,
  output logic              o_done_valid,
  input  logic              i_done_ready,
  output logic [ID_W-1:0]   o_done_id,
  output logic [TILE_W-1:0] o_done_tiles,
  output logic              o_done_err,
  output logic              o_busy
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [31:0]       o_perf_cycles,
  output logic [31:0]       o_perf_stall
`endif
);

  localparam int FW = 2 + ID_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  logic [2:0]        state;
  logic              ready_en;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_rdata;
  logic [1:0]        job_mode;
  logic [ID_W-1:0]   job_id;
  logic [TILE_W-1:0] tile_cnt;
  logic [DW-1:0]     drain_cnt;
  logic              stray;

  // Commands are accepted only once reset has been released for a cycle.
  assign o_cmd_ready = ready_en && !fifo_full;
  assign fifo_push   = i_cmd_valid && o_cmd_ready;
  assign fifo_pop    = (state == S_IDLE) && !fifo_empty && !i_flush;

  mm_sched_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (i_flush),
    .wdata ({i_cmd_mode, i_cmd_id}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Hold o_cmd_ready low through reset and raise it on the first clock after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Job sequencing: pop, issue, count tiles, drain, report.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      job_mode  <= '0;
      job_id    <= '0;
      tile_cnt  <= '0;
      drain_cnt <= '0;
      stray     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            job_mode <= fifo_rdata[FW-1 -: 2];
            job_id   <= fifo_rdata[ID_W-1:0];
            tile_cnt <= '0;
            stray    <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_RUN;
        S_RUN: begin
          // A tile finishing alongside the matrix still belongs to this job.
          if (i_mm_tile_done && (tile_cnt != '1)) tile_cnt <= tile_cnt + TILE_W'(1);
          if (i_mm_mtrx_done) begin
            drain_cnt <= DW'(DRAIN_CYC - 1);
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Any completion pulse here means the controller and scheduler disagree.
          if (i_mm_tile_done || i_mm_mtrx_done) stray <= 1'b1;
          if (drain_cnt == '0) state <= S_REPORT;
          else                 drain_cnt <= drain_cnt - DW'(1);
        end
        S_REPORT: begin
          if (i_done_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_mm_start   = (state == S_ISSUE);
  assign o_mm_mode    = job_mode;
  assign o_done_valid = (state == S_REPORT);
  assign o_done_id    = job_id;
  assign o_done_tiles = tile_cnt;
  assign o_done_err   = o_done_valid && ((tile_cnt != TILE_W'(EXP_TILES)) || stray);
  assign o_busy       = (state != S_IDLE) || (fifo_count != '0);

`ifdef MM_SCHED_PERF_EN
  logic [31:0] run_cyc;

  // Job latency (ISSUE through the REPORT handshake, inclusive) and
  // cumulative completion back-pressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_cyc       <= '0;
      o_perf_cycles <= '0;
      o_perf_stall  <= '0;
    end else begin
      if (state == S_ISSUE)     run_cyc <= 32'd1;
      else if (run_cyc != '1)   run_cyc <= run_cyc + 32'd1;
      if (o_done_valid && i_done_ready) o_perf_cycles <= run_cyc + 32'd1;
      if (o_done_valid && !i_done_ready && (o_perf_stall != '1))
        o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_sched.sv
// Self-checking bench for mm_sched: directed scenarios plus randomized jobs,
// checked against a queue-based model of the commands and completion records.
module tb_mm_sched;
  import mm_sched_pkg::*;

  localparam int ID_W   = 4;
  localparam int TILE_W = 16;
  localparam int EXP    = EXP_TILES_DEF;
  localparam int D      = DRAIN_CYC_DEF;
  localparam int BUDGET = 200;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [1:0]        i_cmd_mode = '0;
  logic [ID_W-1:0]   i_cmd_id = '0;
  logic              i_flush = 1'b0;
  logic              o_mm_start;
  logic [1:0]        o_mm_mode;
  logic              i_mm_tile_done = 1'b0;
  logic              i_mm_mtrx_done = 1'b0;
  logic              o_done_valid;
  logic              i_done_ready = 1'b0;
  logic [ID_W-1:0]   o_done_id;
  logic [TILE_W-1:0] o_done_tiles;
  logic              o_done_err;
  logic              o_busy;
`ifdef MM_SCHED_PERF_EN
  logic [31:0]       o_perf_cycles;
  logic [31:0]       o_perf_stall;
`endif

  mm_sched dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_mode     (i_cmd_mode),
    .i_cmd_id       (i_cmd_id),
    .i_flush        (i_flush),
    .o_mm_start     (o_mm_start),
    .o_mm_mode      (o_mm_mode),
    .i_mm_tile_done (i_mm_tile_done),
    .i_mm_mtrx_done (i_mm_mtrx_done),
    .o_done_valid   (o_done_valid),
    .i_done_ready   (i_done_ready),
    .o_done_id      (o_done_id),
    .o_done_tiles   (o_done_tiles),
    .o_done_err     (o_done_err),
    .o_busy         (o_busy)
`ifdef MM_SCHED_PERF_EN
    ,
    .o_perf_cycles  (o_perf_cycles),
    .o_perf_stall   (o_perf_stall)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]      mode;
    logic [ID_W-1:0] id;
  } job_t;

  job_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_starts = 0;
  int   n_consumed = 0;
  int   start_double = 0;
  int   start_cyc_q[$];
  logic start_prev = 1'b0;
  int   prev_start = -1;
  int   report_cyc = -1;

  always @(posedge i_clk) cyc++;

  // Start-pulse monitor: records the cycle of every start and flags wide pulses.
  always @(negedge i_clk) begin
    if (o_mm_start) begin
      n_starts++;
      start_cyc_q.push_back(cyc);
      if (start_prev) start_double++;
    end
    start_prev = o_mm_start;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] mode, input logic [ID_W-1:0] id);
    int k = 0;
    i_cmd_valid = 1'b1;
    i_cmd_mode  = mode;
    i_cmd_id    = id;
    while (!o_cmd_ready && k < BUDGET) begin
      tick();
      k++;
    end
    check("push_accept", k < BUDGET, 1);
    tick();
    i_cmd_valid = 1'b0;
    exp_q.push_back('{mode, id});
  endtask

  task automatic wait_start(input bit b2b);
    int k = 0;
    int sc;
    while (n_starts <= n_consumed && k < BUDGET) begin
      tick();
      k++;
    end
    check("start_seen", n_starts > n_consumed, 1);
    if (n_starts > n_consumed) begin
      sc = start_cyc_q[n_consumed];
      n_consumed++;
      if (prev_start >= 0) check("start_spacing_min", (sc - prev_start) >= D + 3, 1);
      if (b2b) check("b2b_issue_gap", sc - report_cyc, 2);
      prev_start = sc;
    end
  endtask

  // Drives one job through the controller side and checks its completion record.
  task automatic run_job(input int ntiles, input bit same, input bit stray,
                         input int hold, input bit b2b, input bit flush_mid);
    job_t              job;
    int                k;
    logic [TILE_W-1:0] exp_t;
    logic              exp_e;
    wait_start(b2b);
    check("model_has_job", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    job = exp_q.pop_front();
    check("mm_mode_run", o_mm_mode, job.mode);
    if (flush_mid) begin
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      exp_q.delete();
    end
    for (int t = 0; t < ntiles; t++) begin
      if (!(same && t == ntiles - 1)) begin
        i_mm_tile_done = 1'b1;
        tick();
        i_mm_tile_done = 1'b0;
        if ($urandom_range(1, 0) == 1) tick();
      end
    end
    i_mm_mtrx_done = 1'b1;
    i_mm_tile_done = same && ntiles > 0;
    tick();
    i_mm_mtrx_done = 1'b0;
    i_mm_tile_done = 1'b0;
    k = 0;
    while (!o_done_valid && k < BUDGET) begin
      i_mm_tile_done = stray && k == 0;
      tick();
      i_mm_tile_done = 1'b0;
      k++;
    end
    check("drain_len", k, D);
    exp_t = TILE_W'(ntiles);
    exp_e = (ntiles != EXP) || stray;
    check("done_valid", o_done_valid, 1);
    check("done_id", o_done_id, job.id);
    check("done_tiles", o_done_tiles, exp_t);
    check("done_err", o_done_err, exp_e);
    check("mm_mode_held", o_mm_mode, job.mode);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", o_done_valid, 1);
      check("hold_id", o_done_id, job.id);
      check("hold_tiles", o_done_tiles, exp_t);
      check("hold_err", o_done_err, exp_e);
      check("hold_no_start", o_mm_start, 0);
    end
    i_done_ready = 1'b1;
    tick();
    i_done_ready = 1'b0;
    report_cyc = cyc - 1;
    check("done_valid_drop", o_done_valid, 0);
    check("mode_held_idle", o_mm_mode, job.mode);
  endtask

  initial begin
    int s0;
    logic [1:0] m;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", o_cmd_ready, 0);
    check("rst_mm_start", o_mm_start, 0);
    check("rst_mm_mode", o_mm_mode, 0);
    check("rst_done_valid", o_done_valid, 0);
    check("rst_done_err", o_done_err, 0);
    check("rst_done_tiles", o_done_tiles, 0);
    check("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    #1;
    check("ready_before_edge", o_cmd_ready, 0);
    tick();
    check("ready_after_release", o_cmd_ready, 1);

    // Single well-formed job
    s0 = n_starts;
    push(MODE_INT8, 4'd3);
    run_job(EXP, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("single_start_count", n_starts - s0, 1);
    check("idle_not_busy", o_busy, 0);

    // Short tile count, then a stray tile in the drain window
    push(MODE_INT4, 4'd5);
    run_job(EXP - 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    push(MODE_INT4_VSQ, 4'd6);
    run_job(EXP, 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Full FIFO: first command is popped, four more fill the queue
    for (int i = 0; i < 5; i++) push(2'($urandom_range(2, 0)), ID_W'(8 + i));
    check("full_ready_low", o_cmd_ready, 0);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = MODE_INT4;
    i_cmd_id    = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_stays_full", o_cmd_ready, 0);
    end
    i_cmd_valid = 1'b0;
    run_job(EXP, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_job(EXP, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    check("full_drained", o_busy, 0);

    // Completion back-pressure with a second job waiting
    push(MODE_INT4, 4'd1);
    push(MODE_INT8, 4'd2);
    run_job(EXP, 1'b0, 1'b0, 20, 1'b0, 1'b0);
    run_job(EXP, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Randomized jobs
    for (int i = 0; i < 8; i++) begin
      m = 2'($urandom_range(2, 0));
      push(m, ID_W'($urandom));
      run_job($urandom_range(EXP + 1, EXP - 1), 1'($urandom_range(1, 0)),
              $urandom_range(3, 0) == 0, $urandom_range(3, 0), 1'b0, 1'b0);
    end

    // Flush during RUN of the first of three queued jobs
    push(MODE_INT8, 4'd10);
    push(MODE_INT4, 4'd11);
    push(MODE_INT4_VSQ, 4'd12);
    run_job(EXP, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("flush_not_busy", o_busy, 0);
    s0 = n_starts;
    repeat (20) tick();
    check("flush_no_more_starts", n_starts - s0, 0);

    // Flush wins over a push in the same cycle
    i_cmd_valid = 1'b1;
    i_cmd_mode  = MODE_INT4;
    i_cmd_id    = 4'd7;
    i_flush     = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_flush     = 1'b0;
    check("flush_beats_push", o_busy, 0);
    repeat (5) tick();
    check("flush_push_no_start", n_starts - s0, 0);

    // Reset in the middle of a job with another command still queued
    push(MODE_INT4_VSQ, 4'd9);
    push(MODE_INT4, 4'd13);
    wait_start(1'b0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      i_mm_tile_done = 1'b1;
      tick();
      i_mm_tile_done = 1'b0;
    end
    i_rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", o_cmd_ready, 0);
    check("midrst_mm_start", o_mm_start, 0);
    check("midrst_mm_mode", o_mm_mode, 0);
    check("midrst_done_valid", o_done_valid, 0);
    check("midrst_done_id", o_done_id, 0);
    check("midrst_done_tiles", o_done_tiles, 0);
    check("midrst_busy", o_busy, 0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    prev_start = -1;
    s0 = n_starts;
    tick();
    check("postrst_ready", o_cmd_ready, 1);
    repeat (4) tick();
    check("postrst_no_start", n_starts - s0, 0);
    check("postrst_not_busy", o_busy, 0);
    push(MODE_INT8, 4'd4);
    run_job(EXP, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    check("start_single_cycle", start_double, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mm_sched.md
Name: mm_sched

Overview:
- Job scheduler in front of the matrix-multiply controller.
- Accepts matmul commands (mode + job ID) into a small FIFO and issues one start pulse per job.
- Tracks tile/matrix completion, enforces the post-matrix drain window, and returns a completion record (ID, tile count, error flag) over a valid/ready port.
- Sits between the host/command decoder and the MM controller; is the only driver of the MM controller's start/mode inputs.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- ID_W, 4, job ID width
- TILE_W, 16, tile counter width
- DRAIN_CYC, `VL, cycles to wait after matrix-done before the next start (MM controller PPU flush)
- EXP_TILES, (`N/`AD)*(`M/`VL), expected tile_done pulses per job

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  FIFO not full
- i_cmd_mode  in  2  `INT8 / `INT4 / `INT4_VSQ
- i_cmd_id  in  ID_W  job tag
- i_flush  in  1  drop all queued, not-yet-issued commands
- o_mm_start  out  1  one-cycle start pulse to MM controller
- o_mm_mode  out  2  mode held stable from start until job completes
- i_mm_tile_done  in  1  tile-done pulse
- i_mm_mtrx_done  in  1  matrix-done pulse
- o_done_valid  out  1  completion record valid
- i_done_ready  in  1  completion accepted
- o_done_id  out  ID_W  ID of completed job
- o_done_tiles  out  TILE_W  tile_done pulses counted for the job
- o_done_err  out  1  tile count ≠ EXP_TILES
- o_busy  out  1  state ≠ IDLE or FIFO non-empty

Behaviour:
- Reset: all outputs 0; o_cmd_ready goes 1 on the first cycle after reset release. FIFO emptied, state IDLE, counters 0. Reset mid-job abandons the job with no completion record.
- FIFO:
  - Push when i_cmd_valid && o_cmd_ready; o_cmd_ready = !full (registered count).
  - Push and pop in the same cycle are allowed when full; the count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- State machine IDLE → ISSUE → RUN → DRAIN → REPORT → IDLE:
  - IDLE: if FIFO non-empty and !i_flush, pop the head, latch mode/ID into job registers, clear the tile counter → ISSUE.
  - ISSUE: o_mm_start=1 for exactly this cycle; o_mm_mode=latched mode → RUN.
  - RUN:
    - Each i_mm_tile_done increments the tile counter, saturating at all-ones.
    - On i_mm_mtrx_done → DRAIN, loading the drain counter with DRAIN_CYC-1.
    - A tile_done in the same cycle as mtrx_done is counted.
  - DRAIN: decrement each cycle; at 0 → REPORT. tile/mtrx pulses in DRAIN are ignored and set the error flag.
  - REPORT:
    - o_done_valid=1 with ID/tiles/err stable until i_done_ready; on handshake → IDLE.
    - o_done_err = (tiles ≠ EXP_TILES) | stray pulse seen.
- Start-to-start spacing is at least DRAIN_CYC+3 cycles. A new start never coincides with the MM controller's DONE window.
- i_flush: clears the FIFO in 1 cycle; an active job continues to completion. Flush beats push in the same cycle, so the pushed command is dropped.
- o_mm_mode is held at the last job's mode while IDLE; no glitch between jobs.
- Back-to-back: with REPORT accepted the same cycle and FIFO non-empty, the next ISSUE follows 2 cycles later (IDLE, then ISSUE).

Optional Feature:
- Macro MM_SCHED_PERF_EN.
- When defined:
  - Adds output o_perf_cycles [31:0]: cycles from ISSUE to the REPORT handshake for the last completed job.
  - Adds output o_perf_stall [31:0]: cumulative cycles in REPORT with i_done_ready=0, since reset.
  - Both reset to 0; o_perf_stall saturates.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/define file holds the state encodings (S_IDLE…S_REPORT), the mode encodings (reuse `INT8/`INT4/`INT4_VSQ), and the EXP_TILES derivation from `M/`N/`VL/`AD.
- One sub-module is natural: sync_fifo (parameterised WIDTH=2+ID_W, DEPTH=FIFO_DEPTH, full/empty/count). The FSM and counters stay in mm_sched.

Test Plan:
- Single job: push mode=`INT8, id=3, drive EXP_TILES tile pulses then mtrx_done → exactly one o_mm_start; done_valid after DRAIN_CYC cycles with id=3, tiles=EXP_TILES, err=0.
- Full FIFO: push 5 commands with i_done_ready=1 → o_cmd_ready=0 after 4 queued (or after 5 if one popped). All IDs complete in push order; start spacing ≥ DRAIN_CYC+3.
- Backpressure: hold i_done_ready=0 for 20 cycles with 2 jobs queued → no second o_mm_start until handshake; o_done_* stable throughout.
- Error: send EXP_TILES-1 tile pulses then mtrx_done → err=1, tiles=EXP_TILES-1. Separately, a tile pulse during DRAIN → err=1.
- Flush: queue 3 jobs, assert i_flush during RUN of job 1 → job 1 reports, no further starts, o_busy=0 after report.
- Reset: assert i_rst_n=0 in RUN → all outputs 0 immediately; after release a new push starts cleanly with tiles counted from 0.
